// File: rtl/conv_encoder.sv
// Rate-1/2 feedforward convolutional encoder, constraint length K.
// Serial framed input with a valid/ready handshake, one 2-bit symbol out per
// input bit, a single registered output stage.
// Build option: define CONV_ENC_TAIL_EN to append K-1 zero tail bits after the
// din_last bit so the trellis terminates in state 0. Without it, a frame ends
// on the din_last symbol and the shift register is simply cleared.
//
// Handshake: a beat moves on any rising edge where valid && ready are both
// high. The producer holds data and qualifiers stable until that edge. On the
// output side, enc_pair/enc_last stay frozen while enc_valid=1 and enc_ready=0.
module conv_encoder #(
  parameter int             K  = 3,
  parameter logic [K-1:0]   G0 = 3'b111,
  parameter logic [K-1:0]   G1 = 3'b101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
  input  logic       din_last,
  output logic       din_ready,
  output logic [1:0] enc_pair,
  output logic       enc_valid,
  output logic       enc_last,
  input  logic       enc_ready,
  output logic       busy,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1
`ifdef CONV_ENC_TAIL_EN
    ,
    S_TAIL = 2'd2
`endif
  } state_t;

  state_t         state;
  logic [K-2:0]   sr;      // sr[K-2] = most recent bit, sr[0] = oldest
  logic           adv;     // output stage may load this cycle
  logic [K-1:0]   v_in;    // encoder vector with the incoming data bit

`ifdef CONV_ENC_TAIL_EN
  localparam int CW = $clog2(K);
  logic [CW-1:0]  tail_cnt;
  logic [K-1:0]   v_tail;  // encoder vector with a zero tail bit
`endif

  // One code symbol: each output bit is the parity of the tapped vector bits.
  function automatic logic [1:0] encode(input logic [K-1:0] v);
    return {^(v & G0), ^(v & G1)};
  endfunction

  // Handshake and status decode.
  always_comb begin
    adv       = !enc_valid || enc_ready;
    din_ready = adv && (state == S_IDLE || state == S_DATA);
    busy      = (state != S_IDLE) || enc_valid;
    state_dbg = state;
    v_in      = {din, sr};
`ifdef CONV_ENC_TAIL_EN
    v_tail    = {1'b0, sr};
`endif
  end

  // Control FSM, shift register and output stage advance together on adv.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      sr        <= '0;
      enc_pair  <= 2'b00;
      enc_valid <= 1'b0;
      enc_last  <= 1'b0;
`ifdef CONV_ENC_TAIL_EN
      tail_cnt  <= '0;
`endif
    end else if (adv) begin
      case (state)
        S_IDLE, S_DATA: begin
          if (din_valid) begin
            enc_pair  <= encode(v_in);
            enc_valid <= 1'b1;
            if (din_last) begin
`ifdef CONV_ENC_TAIL_EN
              state    <= S_TAIL;
              tail_cnt <= CW'(K - 1);
              sr       <= v_in[K-1:1];
              enc_last <= 1'b0;
`else
              // Unterminated frame end: restart the next frame from state 0.
              state    <= S_IDLE;
              sr       <= '0;
              enc_last <= 1'b1;
`endif
            end else begin
              state    <= S_DATA;
              sr       <= v_in[K-1:1];
              enc_last <= 1'b0;
            end
          end else begin
            // Held symbol was taken (or none was present); nothing new to emit.
            enc_valid <= 1'b0;
            enc_last  <= 1'b0;
          end
        end
`ifdef CONV_ENC_TAIL_EN
        S_TAIL: begin
          enc_pair  <= encode(v_tail);
          enc_valid <= 1'b1;
          tail_cnt  <= tail_cnt - CW'(1);
          if (tail_cnt == CW'(1)) begin
            state    <= S_IDLE;
            sr       <= '0;
            enc_last <= 1'b1;
          end else begin
            sr       <= v_tail[K-1:1];
            enc_last <= 1'b0;
          end
        end
`endif
        default: begin
          state     <= S_IDLE;
          sr        <= '0;
          enc_valid <= 1'b0;
          enc_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule
